// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: owns the trap CSRs and arbitrates exceptions,
// interrupts, MRET and WFI into a registered PC redirect.
module trap_controller #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   input  logic [XLEN-1:0] instr_pc,
   input  logic            exc_request,
   input  logic [XLEN-1:0] exc_cause,
   input  logic            exc_ret,
   input  logic            is_wfi,
   input  logic            timer_irq,
   input  logic            ext_irq,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            kill,
   output logic            stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            trap_taken
);

   typedef enum logic [1:0] {RUN, JUMP, SLEEP} state_t;

   localparam logic [XLEN-1:0] CAUSE_MEI  = {1'b1, (XLEN-1)'(11)};
   localparam logic [XLEN-1:0] CAUSE_MTI  = {1'b1, (XLEN-1)'(7)};
   localparam logic [XLEN-1:0] LOW2_CLEAR = ~XLEN'(3);
   localparam logic [XLEN-1:0] MSB_CLEAR  = {1'b0, {(XLEN-1){1'b1}}};

   state_t          r_state;
   logic            r_mstatusMie;
   logic            r_mstatusMpie;
   logic            r_mieMtie;
   logic            r_mieMeie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_wfiPc;
   logic [XLEN-1:0] r_redirectPc;
   logic            r_redirectValid;
   logic            r_trapTaken;

   logic            w_run;
   logic            w_extHit;
   logic            w_tmrHit;
   logic            w_isIrq;
   logic            w_retire;
   logic            w_trapRun;
   logic            w_mretRun;
   logic            w_wfiRun;
   logic            w_wake;
   logic            w_trapWake;
   logic            w_trap;
   logic [XLEN-1:0] w_cause;
   logic [XLEN-1:0] w_base;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_wfiNext;
   logic [XLEN-1:0] w_trapPc;

   assign w_run      = (r_state == RUN);
   assign w_extHit   = r_mstatusMie & r_mieMeie & ext_irq;
   assign w_tmrHit   = r_mstatusMie & r_mieMtie & timer_irq;
   assign w_isIrq    = w_extHit | w_tmrHit;
   assign w_retire   = w_run & instr_valid;
   assign w_trapRun  = w_retire & (w_isIrq | exc_request);
   assign w_mretRun  = w_retire & ~w_trapRun & exc_ret;
   assign w_wfiRun   = w_retire & ~w_trapRun & ~exc_ret & is_wfi;
   // Wake-up ignores the global MIE; only a globally enabled source becomes a trap.
   assign w_wake     = (r_state == SLEEP) & ((timer_irq & r_mieMtie) | (ext_irq & r_mieMeie));
   assign w_trapWake = w_wake & w_isIrq;
   assign w_trap     = w_trapRun | w_trapWake;

   assign w_cause   = w_extHit ? CAUSE_MEI : (w_tmrHit ? CAUSE_MTI : (exc_cause & MSB_CLEAR));
   assign w_base    = r_mtvec & LOW2_CLEAR;
   assign w_target  = ((r_mtvec[1:0] == 2'b01) && w_isIrq) ? (w_base + (w_cause << 2)) : w_base;
   assign w_wfiNext = r_wfiPc + XLEN'(4);
   assign w_trapPc  = w_trapWake ? w_wfiNext : instr_pc;

   assign kill           = w_trapRun;
   assign stall          = (r_state != RUN);
   assign redirect_valid = r_redirectValid;
   assign redirect_pc    = r_redirectPc;
   assign trap_taken     = r_trapTaken;

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         12'h300: begin
            csr_rdata[3] = r_mstatusMie;
            csr_rdata[7] = r_mstatusMpie;
         end
         12'h304: begin
            csr_rdata[7]  = r_mieMtie;
            csr_rdata[11] = r_mieMeie;
         end
         12'h305: csr_rdata = r_mtvec;
         12'h341: csr_rdata = r_mepc;
         12'h342: csr_rdata = r_mcause;
         12'h344: begin
            csr_rdata[7]  = timer_irq;
            csr_rdata[11] = ext_irq;
         end
         default: csr_rdata = '0;
      endcase
   end

   // CSR writes land first so that trap and MRET side effects override them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= RUN;
         r_mstatusMie    <= 1'b0;
         r_mstatusMpie   <= 1'b0;
         r_mieMtie       <= 1'b0;
         r_mieMeie       <= 1'b0;
         r_mtvec         <= MTVEC_RESET;
         r_mepc          <= '0;
         r_mcause        <= '0;
         r_wfiPc         <= '0;
         r_redirectPc    <= '0;
         r_redirectValid <= 1'b0;
         r_trapTaken     <= 1'b0;
      end else begin
         r_redirectValid <= 1'b0;
         r_trapTaken     <= 1'b0;
         if (csr_we && w_run && !w_trapRun) begin
            case (csr_addr)
               12'h300: begin
                  r_mstatusMie  <= csr_wdata[3];
                  r_mstatusMpie <= csr_wdata[7];
               end
               12'h304: begin
                  r_mieMtie <= csr_wdata[7];
                  r_mieMeie <= csr_wdata[11];
               end
               12'h305: r_mtvec  <= csr_wdata;
               12'h341: r_mepc   <= csr_wdata & LOW2_CLEAR;
               12'h342: r_mcause <= csr_wdata;
               default: ;
            endcase
         end
         if (w_trap) begin
            r_mepc          <= w_trapPc & LOW2_CLEAR;
            r_mcause        <= w_cause;
            r_mstatusMpie   <= r_mstatusMie;
            r_mstatusMie    <= 1'b0;
            r_redirectPc    <= w_target;
            r_redirectValid <= 1'b1;
            r_trapTaken     <= 1'b1;
            r_state         <= JUMP;
         end else if (w_mretRun) begin
            r_mstatusMie    <= r_mstatusMpie;
            r_mstatusMpie   <= 1'b1;
            r_redirectPc    <= r_mepc;
            r_redirectValid <= 1'b1;
            r_state         <= JUMP;
         end else if (w_wfiRun) begin
            r_wfiPc <= instr_pc;
            r_state <= SLEEP;
         end else if (w_wake) begin
            r_redirectPc    <= w_wfiNext;
            r_redirectValid <= 1'b1;
            r_state         <= JUMP;
         end else if (r_state == JUMP) begin
            r_state <= RUN;
         end
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: a behavioural CSR/trap model predicts every
// redirect, and a separate monitor pops those predictions when the DUT redirects.
module tb_trap_controller;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic        exc;
      logic [31:0] cause;
      logic        ret;
      logic        wfi;
      logic        tmr;
      logic        ext;
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
   } stim_t;

   typedef struct {
      logic [31:0] pc;
      logic        trap;
   } redirect_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr_pc = '0;
   logic        exc_request = 1'b0;
   logic [31:0] exc_cause = '0;
   logic        exc_ret = 1'b0;
   logic        is_wfi = 1'b0;
   logic        timer_irq = 1'b0;
   logic        ext_irq = 1'b0;
   logic        csr_we = 1'b0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wdata = '0;
   logic [31:0] csr_rdata;
   logic        kill;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        trap_taken;

   int nCompared = 0;
   int nMismatched = 0;

   // Reference model of the architectural trap state.
   bit          mMie, mMpie, mMtie, mMeie;
   logic [31:0] mMtvec, mMepc, mMcause, mWfiPc;
   bit          mSleep, mJump, mJumpTrap;
   redirect_t   expQ[$];

   trap_controller #(.XLEN(32), .MTVEC_RESET(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_pc(instr_pc),
      .exc_request(exc_request), .exc_cause(exc_cause), .exc_ret(exc_ret),
      .is_wfi(is_wfi), .timer_irq(timer_irq), .ext_irq(ext_irq), .csr_we(csr_we),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .kill(kill),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap_taken(trap_taken)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   function automatic stim_t idleStim(input logic [11:0] a);
      stim_t s;
      s = '{default: '0};
      s.addr = a;
      return s;
   endfunction

   function automatic logic [31:0] modelRead(input logic [11:0] a, input logic tmr, input logic ext);
      case (a)
         12'h300: return (32'(mMie) << 3) | (32'(mMpie) << 7);
         12'h304: return (32'(mMtie) << 7) | (32'(mMeie) << 11);
         12'h305: return mMtvec;
         12'h341: return mMepc;
         12'h342: return mMcause;
         12'h344: return (32'(tmr) << 7) | (32'(ext) << 11);
         default: return 32'h0;
      endcase
   endfunction

   task automatic modelReset();
      mMie = 0; mMpie = 0; mMtie = 0; mMeie = 0;
      mMtvec = 32'h0; mMepc = 32'h0; mMcause = 32'h0; mWfiPc = 32'h0;
      mSleep = 0; mJump = 0; mJumpTrap = 0;
      expQ.delete();
   endtask

   task automatic takeTrap(input logic [31:0] cause, input bit isIrq, input logic [31:0] pc);
      logic [31:0] base;
      logic [31:0] tgt;
      base = mMtvec & ~32'h3;
      tgt = (isIrq && mMtvec[1:0] == 2'd1) ? base + 32'd4 * (cause & 32'h7FFF_FFFF) : base;
      mMepc = pc & ~32'h3;
      mMcause = cause;
      mMpie = mMie;
      mMie = 0;
      expQ.push_back('{tgt, 1'b1});
      mJump = 1;
      mJumpTrap = 1;
   endtask

   task automatic modelStep(input stim_t s);
      bit irqE, irqT;
      irqE = mMie && mMeie && s.ext;
      irqT = mMie && mMtie && s.tmr;
      if (mJump) begin
         mJump = 0;
         mJumpTrap = 0;
      end else if (mSleep) begin
         if ((s.tmr && mMtie) || (s.ext && mMeie)) begin
            mSleep = 0;
            if (irqE || irqT) begin
               takeTrap(irqE ? 32'h8000_000B : 32'h8000_0007, 1'b1, mWfiPc + 32'd4);
            end else begin
               expQ.push_back('{mWfiPc + 32'd4, 1'b0});
               mJump = 1;
               mJumpTrap = 0;
            end
         end
      end else if (s.valid && (irqE || irqT || s.exc)) begin
         takeTrap(irqE ? 32'h8000_000B : (irqT ? 32'h8000_0007 : (s.cause & 32'h7FFF_FFFF)),
                  irqE || irqT, s.pc);
      end else begin
         if (s.we) begin
            case (s.addr)
               12'h300: begin mMie = s.wdata[3]; mMpie = s.wdata[7]; end
               12'h304: begin mMtie = s.wdata[7]; mMeie = s.wdata[11]; end
               12'h305: mMtvec = s.wdata;
               12'h341: mMepc = s.wdata & ~32'h3;
               12'h342: mMcause = s.wdata;
               default: ;
            endcase
         end
         if (s.valid && s.ret) begin
            expQ.push_back('{mMepc, 1'b0});
            mMie = mMpie;
            mMpie = 1;
            mJump = 1;
            mJumpTrap = 0;
         end else if (s.valid && s.wfi) begin
            mSleep = 1;
            mWfiPc = s.pc;
         end
      end
   endtask

   // One core cycle: drive after the falling edge, check combinational and
   // registered outputs against the model, then advance the model.
   task automatic applyStimulus(input stim_t s);
      bit expKill;
      @(negedge clk);
      instr_valid = s.valid; instr_pc = s.pc; exc_request = s.exc; exc_cause = s.cause;
      exc_ret = s.ret; is_wfi = s.wfi; timer_irq = s.tmr; ext_irq = s.ext;
      csr_we = s.we; csr_addr = s.addr; csr_wdata = s.wdata;
      #1;
      expKill = !mSleep && !mJump && s.valid &&
                ((mMie && mMeie && s.ext) || (mMie && mMtie && s.tmr) || s.exc);
      checkOutput("kill", 32'(kill), 32'(expKill));
      checkOutput("stall", 32'(stall), 32'(mSleep || mJump));
      checkOutput("redirect_valid", 32'(redirect_valid), 32'(mJump));
      checkOutput("trap_taken level", 32'(trap_taken), 32'(mJump && mJumpTrap));
      checkOutput($sformatf("csr_rdata[%h]", s.addr), csr_rdata, modelRead(s.addr, s.tmr, s.ext));
      modelStep(s);
   endtask

   task automatic writeCsr(input logic [11:0] a, input logic [31:0] d);
      stim_t s;
      s = idleStim(a);
      s.we = 1'b1;
      s.wdata = d;
      applyStimulus(s);
   endtask

   task automatic resetDut(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      instr_valid = 0; exc_request = 0; exc_ret = 0; is_wfi = 0; timer_irq = 0; ext_irq = 0;
      csr_we = 0; csr_addr = 12'h305; csr_wdata = '0;
      modelReset();
      #1;
      checkOutput({tag, " stall"}, 32'(stall), 32'h0);
      checkOutput({tag, " redirect_valid"}, 32'(redirect_valid), 32'h0);
      checkOutput({tag, " trap_taken"}, 32'(trap_taken), 32'h0);
      checkOutput({tag, " redirect_pc"}, redirect_pc, 32'h0);
      checkOutput({tag, " kill"}, 32'(kill), 32'h0);
      checkOutput({tag, " mtvec"}, csr_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every DUT redirect must match the oldest predicted redirect.
   initial begin
      redirect_t e;
      forever begin
         @(negedge clk);
         if (rst_n && redirect_valid) begin
            if (expQ.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL unexpected redirect: got pc %h, required no redirect", redirect_pc);
            end else begin
               e = expQ.pop_front();
               checkOutput("redirect_pc", redirect_pc, e.pc);
               checkOutput("trap_taken", 32'(trap_taken), 32'(e.trap));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      nMismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      stim_t s;
      logic [11:0] addrList [7];
      addrList = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
      modelReset();
      resetDut("reset");

      $display("[TB] ECALL, direct mode");
      writeCsr(12'h305, 32'h100);
      writeCsr(12'h300, 32'h8);
      s = idleStim(12'h300);
      s.valid = 1; s.pc = 32'h40; s.exc = 1; s.cause = 32'd11;
      applyStimulus(s);
      checkOutput("ecall kill", 32'(kill), 32'h1);
      applyStimulus(idleStim(12'h341));
      checkOutput("ecall redirect_pc", redirect_pc, 32'h100);
      checkOutput("ecall trap_taken", 32'(trap_taken), 32'h1);
      checkOutput("ecall mepc", csr_rdata, 32'h40);
      applyStimulus(idleStim(12'h342));
      checkOutput("ecall mcause", csr_rdata, 32'd11);
      applyStimulus(idleStim(12'h300));
      checkOutput("ecall mstatus", csr_rdata, 32'h80);

      $display("[TB] vectored timer interrupt");
      writeCsr(12'h305, 32'h201);
      writeCsr(12'h304, 32'h80);
      writeCsr(12'h300, 32'h8);
      s = idleStim(12'h305);
      s.valid = 1; s.pc = 32'h10; s.tmr = 1;
      applyStimulus(s);
      applyStimulus(idleStim(12'h342));
      checkOutput("vector redirect_pc", redirect_pc, 32'h21C);
      checkOutput("vector mcause", csr_rdata, 32'h8000_0007);

      $display("[TB] MRET");
      writeCsr(12'h341, 32'h44);
      s = idleStim(12'h341);
      s.valid = 1; s.pc = 32'h30; s.ret = 1;
      applyStimulus(s);
      applyStimulus(idleStim(12'h300));
      checkOutput("mret redirect_pc", redirect_pc, 32'h44);
      checkOutput("mret trap_taken", 32'(trap_taken), 32'h0);
      checkOutput("mret mstatus", csr_rdata, 32'h88);

      $display("[TB] simultaneous events");
      writeCsr(12'h305, 32'h100);
      writeCsr(12'h304, 32'h880);
      s = idleStim(12'h304);
      s.valid = 1; s.pc = 32'h60; s.exc = 1; s.cause = 32'd2; s.tmr = 1; s.ext = 1;
      applyStimulus(s);
      applyStimulus(idleStim(12'h342));
      checkOutput("simul mcause", csr_rdata, 32'h8000_000B);
      applyStimulus(idleStim(12'h341));
      checkOutput("simul mepc", csr_rdata, 32'h60);

      $display("[TB] WFI with MIE clear");
      writeCsr(12'h300, 32'h0);
      writeCsr(12'h304, 32'h80);
      s = idleStim(12'h341);
      s.valid = 1; s.pc = 32'h80; s.wfi = 1;
      applyStimulus(s);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(idleStim(12'h341));
         checkOutput("wfi stall", 32'(stall), 32'h1);
      end
      s = idleStim(12'h341);
      s.tmr = 1;
      applyStimulus(s);
      applyStimulus(idleStim(12'h341));
      checkOutput("wfi redirect_pc", redirect_pc, 32'h84);
      checkOutput("wfi trap_taken", 32'(trap_taken), 32'h0);
      checkOutput("wfi mepc", csr_rdata, 32'h60);

      $display("[TB] mtvec write during ECALL");
      writeCsr(12'h300, 32'h8);
      s = idleStim(12'h305);
      s.valid = 1; s.pc = 32'h90; s.exc = 1; s.cause = 32'd8; s.we = 1; s.wdata = 32'h300;
      applyStimulus(s);
      applyStimulus(idleStim(12'h305));
      checkOutput("dropped mtvec write", csr_rdata, 32'h100);

      $display("[TB] reset while sleeping");
      writeCsr(12'h304, 32'h0);
      s = idleStim(12'h304);
      s.valid = 1; s.pc = 32'hA0; s.wfi = 1;
      applyStimulus(s);
      applyStimulus(idleStim(12'h304));
      applyStimulus(idleStim(12'h304));
      resetDut("sleep reset");
      applyStimulus(idleStim(12'h300));

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         s.valid = ($urandom_range(0, 3) != 0);
         s.pc    = $urandom & ~32'h3;
         s.exc   = ($urandom_range(0, 7) == 0);
         s.cause = $urandom;
         s.ret   = ($urandom_range(0, 9) == 0);
         s.wfi   = ($urandom_range(0, 11) == 0);
         s.tmr   = ($urandom_range(0, 5) == 0);
         s.ext   = ($urandom_range(0, 7) == 0);
         s.we    = !s.ret && ($urandom_range(0, 2) == 0);
         s.addr  = addrList[$urandom_range(0, 6)];
         s.wdata = $urandom;
         applyStimulus(s);
      end
      applyStimulus(idleStim(12'h300));
      applyStimulus(idleStim(12'h300));
      @(negedge clk);
      #1;
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
